svm_r_frame_loader: RTL and testbench
=====================================

# svm_r_frame_loader

Sequential front/back stage for the V3 SVM-R regression classifier. It assembles six 4-bit features arriving one per beat on a valid/ready stream into the 24-bit packed vector the combinational classifier consumes. It then registers the classifier's 13-bit signed score and presents it on an output valid/ready stream. It also checks frame length and counts malformed frames.

## Interface

Parameters:
- FEAT_W, 4: bits per feature
- N_FEAT, 6: features per frame
- RES_W, 13: classifier score width (two's complement)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- s_valid  in  1  feature beat valid
- s_ready  out  1  loader accepts a beat
- s_data  in  FEAT_W  unsigned feature value
- s_last  in  1  final beat of frame
- feat_vec  out  FEAT_W*N_FEAT  packed vector to classifier; feature i at bits [4i+3:4i]
- cls_res  in  RES_W  classifier score, combinational from feat_vec
- m_valid  out  1  score valid
- m_ready  in  1  downstream accepts score
- m_data  out  RES_W  registered signed score
- err_len  out  1  one-cycle pulse on malformed frame
- err_cnt  out  8  saturating malformed-frame count

## Operation

- Beat transfer occurs when s_valid && s_ready. Score transfer occurs when m_valid && m_ready.
- States:
  - LOAD: s_ready=1. Each beat writes s_data into slot idx; idx increments.
    - Beat at idx=N_FEAT-1 with s_last=1 → EVAL, idx←0.
    - Beat with s_last=1 at idx<N_FEAT-1 (short frame) → err_len pulse, idx←0, stay LOAD. feat_vec slots keep stale values; no score is produced.
    - Beat at idx=N_FEAT-1 with s_last=0 (long frame) → err_len pulse, idx←0, go to DRAIN.
  - DRAIN: s_ready=1. Beats are discarded. The beat with s_last=1 → LOAD.
  - EVAL: s_ready=0. m_data←cls_res. Next state HOLD.
  - HOLD: m_valid=1, s_ready=0. On m_ready → LOAD, with m_valid low the next cycle.
- err_cnt increments by 1 per err_len pulse and saturates at 255.
- m_data is signed. It is captured bit-exact and never extended or truncated.

## Timing

- Reset values: state LOAD, idx 0, feat_vec 0, m_data 0, m_valid 0, err_len 0, err_cnt 0.
- s_ready is 0 in any cycle where rst=1.
- Reset mid-frame or mid-HOLD drops all partial or pending data. No score is emitted afterwards.
- Latency: last beat accepted in cycle t → feat_vec complete at t+1 (EVAL) → m_valid=1 from t+2.
- Throughput: at most one frame per N_FEAT+2 cycles, including the HOLD handshake cycle at best.
- m_data and m_valid are stable while m_valid && !m_ready.
- feat_vec is registered and changes only on accepted LOAD beats. It stays constant through EVAL and HOLD.
- err_len is registered. It asserts the cycle after the offending beat, for exactly one cycle.
- No combinational path from s_valid or m_ready to any output, except s_ready, which depends on state only.

## Structure

- Shared package svm_r_pkg holds:
  - FEAT_W, N_FEAT, RES_W constants
  - state enum {LOAD, DRAIN, EVAL, HOLD}
  - packed feature-vector typedef
- The classifier is instantiated beside this block, not inside it. A wrapper svm_r_stream_top connects feat_vec→inp and out→cls_res.
- No sub-module is required. An 8-bit saturating counter, sat_cnt8, may be factored into its own module.

## Test plan

The bench connects the V3 SVM-R classifier (weights 5,-61,-13,36,88,-65; intercept 1063) through svm_r_stream_top.
- Frame 1,2,3,4,5,6 with last on beat 6, m_ready=1 → feat_vec 0x654321; m_valid two cycles after beat 6; m_data=1101 (0x44D).
- Frame of six zeros → m_data=1063. Frame of six 15s → m_data=913. Back-to-back frames arrive in order with no loss.
- m_ready held 0 for 10 cycles after m_valid → m_data stable, s_ready=0 throughout. Raising m_ready gives one transfer, then s_ready=1.
- Short frame (last on beat 3), then a valid frame → one err_len pulse, err_cnt=1, exactly one score matching the valid frame.
- Long frame of 8 beats, last on beat 8 → err_len on the 6th beat, beats 7–8 discarded, no score. A following valid frame scores correctly.
- rst asserted during beat 4 and during HOLD → all outputs at reset values the next cycle. No spurious m_valid after release. 300 malformed frames → err_cnt=255.

Source files
------------

// File: rtl/svm_r_pkg.sv
// Shared constants and types for the SVM-R streaming front/back stage.
// Holds the feature geometry, score width, loader FSM states and the packed feature vector type.
package svm_r_pkg;

    localparam int FEAT_W = 4;
    localparam int N_FEAT = 6;
    localparam int RES_W  = 13;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_EVAL  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    typedef logic [FEAT_W*N_FEAT-1:0] feat_vec_t;

endpackage

// File: rtl/svm_r_frame_loader.sv
// Collects N_FEAT features per frame into a packed vector for the classifier,
// registers the returned score onto an output stream and flags malformed frames.
module svm_r_frame_loader
    import svm_r_pkg::*;
#(
    parameter int FEAT_W = svm_r_pkg::FEAT_W,
    parameter int N_FEAT = svm_r_pkg::N_FEAT,
    parameter int RES_W  = svm_r_pkg::RES_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [FEAT_W-1:0]        s_data,
    input  logic                     s_last,
    output logic [FEAT_W*N_FEAT-1:0] feat_vec,
    input  logic [RES_W-1:0]         cls_res,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [RES_W-1:0]         m_data,
    output logic                     err_len,
    output logic [7:0]               err_cnt,
    output state_t                   dbg_state
);

    // Handshake: a beat moves when s_valid && s_ready, a score moves when
    // m_valid && m_ready; s_ready and m_valid are decoded from state alone.

    localparam int IDX_W = $clog2(N_FEAT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

    state_t                    r_state;
    logic [IDX_W-1:0]          r_idx;
    logic [FEAT_W*N_FEAT-1:0]  r_feat;
    logic [RES_W-1:0]          r_m_data;
    logic                      r_err_len;
    logic [7:0]                r_err_cnt;

    logic w_beat;
    logic w_err;

    assign s_ready   = !rst && ((r_state == ST_LOAD) || (r_state == ST_DRAIN));
    assign m_valid   = (r_state == ST_HOLD);
    assign w_beat    = s_valid && s_ready;
    assign feat_vec  = r_feat;
    assign m_data    = r_m_data;
    assign err_len   = r_err_len;
    assign err_cnt   = r_err_cnt;
    assign dbg_state = r_state;

    // Short frame: last before the final slot. Long frame: final slot without last.
    always_comb begin
        w_err = 1'b0;
        if ((r_state == ST_LOAD) && w_beat) begin
            w_err = (r_idx == LAST_IDX) ? !s_last : s_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_LOAD;
            r_idx     <= '0;
            r_feat    <= '0;
            r_m_data  <= '0;
            r_err_len <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_err_len <= w_err;
            if (w_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end

            case (r_state)
                ST_LOAD: begin
                    if (w_beat) begin
                        for (int i = 0; i < N_FEAT; i++) begin
                            if (r_idx == IDX_W'(i)) begin
                                r_feat[i*FEAT_W +: FEAT_W] <= s_data;
                            end
                        end
                        if (r_idx == LAST_IDX) begin
                            r_idx   <= '0;
                            r_state <= s_last ? ST_EVAL : ST_DRAIN;
                        end else if (s_last) begin
                            r_idx <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_beat && s_last) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_EVAL: begin
                    r_m_data <= cls_res;
                    r_state  <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (m_ready) begin
                        r_state <= ST_LOAD;
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_svm_r_frame_loader.sv
// Directed bench for svm_r_frame_loader with a behavioural V3 SVM-R classifier
// (weights 5,-61,-13,36,88,-65; intercept 1063) closing the feat_vec -> cls_res loop.
module tb_svm_r_frame_loader;
    import svm_r_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [3:0]  s_data;
    logic        s_last;
    logic [23:0] feat_vec;
    logic [12:0] cls_res;
    logic        m_valid;
    logic        m_ready;
    logic [12:0] m_data;
    logic        err_len;
    logic [7:0]  err_cnt;
    state_t      dbg_state;

    int total = 0;
    int bad = 0;
    int scores_seen = 0;
    int err_seen = 0;
    int n_push = 0;
    logic [12:0] exp_q[$];
    logic [12:0] mon_exp;

    typedef struct {
        logic [23:0] vec;
        logic [12:0] score;
    } vec_t;
    vec_t tbl[6];

    always #5 clk = ~clk;

    svm_r_frame_loader dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .feat_vec  (feat_vec),
        .cls_res   (cls_res),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .err_len   (err_len),
        .err_cnt   (err_cnt),
        .dbg_state (dbg_state)
    );

    function automatic logic [12:0] classify(input logic [23:0] v);
        int w[6] = '{5, -61, -13, 36, 88, -65};
        int acc = 1063;
        for (int i = 0; i < 6; i++) begin
            acc += w[i] * int'(v[i*4 +: 4]);
        end
        return acc[12:0];
    endfunction

    assign cls_res = classify(feat_vec);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every score transfer pops the oldest expected score.
    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            if (err_len) err_seen++;
            if (m_valid && m_ready) begin
                total++;
                scores_seen++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL spurious_score: got 0x%0h expected none", m_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (m_data !== mon_exp) begin
                        bad++;
                        $display("FAIL score: got 0x%0h expected 0x%0h", m_data, mon_exp);
                    end
                end
            end
        end
    end

    task automatic drive_beat(input logic [3:0] d, input logic l);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            total++;
            bad++;
            $display("FAIL beat_timeout: got s_ready=0 expected 1 within 100 cycles");
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [23:0] v);
        for (int b = 0; b < 6; b++) begin
            drive_beat(v[b*4 +: 4], b == 5);
        end
    endtask

    task automatic expect_score(input logic [12:0] s);
        exp_q.push_back(s);
        n_push++;
    endtask

    task automatic wait_mvalid();
        int n = 0;
        while (!m_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("m_valid_timeout", 32'(m_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
        tbl[0] = '{24'h000000, 13'h0427};
        tbl[1] = '{24'hFFFFFF, 13'h0391};
        tbl[2] = '{24'h0FF00F, 13'h0BB6};
        tbl[3] = '{24'hF000F0, 13'h1CC5};
        tbl[4] = '{24'h2A7193, 13'h05EE};
        tbl[5] = '{24'h654321, 13'h044D};

        repeat (3) @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_s_ready", 32'(s_ready), 32'd1);
        check("reset_m_valid", 32'(m_valid), 32'd0);
        check("reset_feat_vec", 32'(feat_vec), 32'd0);
        check("reset_m_data", 32'(m_data), 32'd0);
        check("reset_err_len", 32'(err_len), 32'd0);
        check("reset_err_cnt", 32'(err_cnt), 32'd0);

        // Latency: EVAL the cycle after the last beat, score the cycle after that.
        expect_score(13'd1101);
        send_frame(24'h654321);
        check("lat_feat_vec", 32'(feat_vec), 32'h654321);
        check("lat_eval_m_valid", 32'(m_valid), 32'd0);
        check("lat_eval_s_ready", 32'(s_ready), 32'd0);
        @(negedge clk);
        check("lat_m_valid", 32'(m_valid), 32'd1);
        check("lat_m_data", 32'(m_data), 32'h44D);

        // Back-to-back table frames.
        for (int i = 0; i < 6; i++) begin
            expect_score(tbl[i].score);
            send_frame(tbl[i].vec);
            check($sformatf("tbl%0d_feat_vec", i), 32'(feat_vec), 32'(tbl[i].vec));
        end
        repeat (3) @(negedge clk);

        // Backpressure for 10 cycles.
        m_ready = 1'b0;
        expect_score(13'd1101);
        send_frame(24'h654321);
        wait_mvalid();
        e0 = scores_seen;
        for (int c = 0; c < 10; c++) begin
            check("stall_m_data", 32'(m_data), 32'h44D);
            check("stall_m_valid", 32'(m_valid), 32'd1);
            check("stall_s_ready", 32'(s_ready), 32'd0);
            check("stall_feat_vec", 32'(feat_vec), 32'h654321);
            @(negedge clk);
        end
        m_ready = 1'b1;
        @(negedge clk);
        check("stall_release_m_valid", 32'(m_valid), 32'd0);
        check("stall_release_s_ready", 32'(s_ready), 32'd1);
        check("stall_one_transfer", 32'(scores_seen - e0), 32'd1);

        // Short frame then a valid frame.
        e0 = err_seen;
        drive_beat(4'd7, 1'b0);
        drive_beat(4'd7, 1'b0);
        drive_beat(4'd7, 1'b1);
        check("short_err_len", 32'(err_len), 32'd1);
        check("short_err_cnt", 32'(err_cnt), 32'd1);
        check("short_state", 32'(dbg_state), 32'(ST_LOAD));
        @(negedge clk);
        check("short_err_len_drop", 32'(err_len), 32'd0);
        expect_score(13'h0BB6);
        send_frame(24'h0FF00F);
        repeat (3) @(negedge clk);
        check("short_err_pulses", 32'(err_seen - e0), 32'd1);

        // Long frame of 8 beats.
        for (int b = 0; b < 6; b++) drive_beat(4'(b + 1), 1'b0);
        check("long_err_len", 32'(err_len), 32'd1);
        check("long_err_cnt", 32'(err_cnt), 32'd2);
        check("long_state", 32'(dbg_state), 32'(ST_DRAIN));
        drive_beat(4'd9, 1'b0);
        check("long_err_len_drop", 32'(err_len), 32'd0);
        drive_beat(4'd9, 1'b1);
        check("long_feat_vec", 32'(feat_vec), 32'h654321);
        check("long_m_valid", 32'(m_valid), 32'd0);
        check("long_s_ready", 32'(s_ready), 32'd1);
        expect_score(13'h1CC5);
        send_frame(24'hF000F0);
        repeat (3) @(negedge clk);

        // Reset during beat 4.
        drive_beat(4'd1, 1'b0);
        drive_beat(4'd2, 1'b0);
        drive_beat(4'd3, 1'b0);
        s_valid = 1'b1; s_data = 4'd4; rst = 1'b1;
        @(negedge clk);
        check("rstbeat_s_ready", 32'(s_ready), 32'd0);
        check("rstbeat_feat_vec", 32'(feat_vec), 32'd0);
        check("rstbeat_m_valid", 32'(m_valid), 32'd0);
        check("rstbeat_m_data", 32'(m_data), 32'd0);
        check("rstbeat_err_len", 32'(err_len), 32'd0);
        check("rstbeat_err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        check("rstbeat_release_s_ready", 32'(s_ready), 32'd1);

        // Reset during HOLD: pending score is dropped.
        m_ready = 1'b0;
        send_frame(24'h654321);
        wait_mvalid();
        rst = 1'b1;
        @(negedge clk);
        check("rsthold_m_valid", 32'(m_valid), 32'd0);
        check("rsthold_m_data", 32'(m_data), 32'd0);
        check("rsthold_feat_vec", 32'(feat_vec), 32'd0);
        rst = 1'b0;
        m_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("rsthold_no_score", 32'(m_valid), 32'd0);
        expect_score(13'h1C02);
        send_frame(24'hF00FF0);
        repeat (3) @(negedge clk);

        // Counter saturation.
        e0 = err_seen;
        for (int k = 0; k < 300; k++) drive_beat(4'd0, 1'b1);
        @(negedge clk);
        check("sat_err_cnt", 32'(err_cnt), 32'd255);
        check("sat_err_pulses", 32'(err_seen - e0), 32'd300);

        repeat (5) @(negedge clk);
        check("scores_pending", 32'(exp_q.size()), 32'd0);
        check("scores_count", 32'(scores_seen), 32'(n_push));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
